pulse_hs_tx: RTL and testbench

PULSE_HS_TX -- requirements
Module: pulse_hs_tx

---
 rtl/pulse_hs_tx.sv | 106 ++++++++++
 tb/tb_pulse_hs_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_hs_tx.sv
// Queues clk1 event strobes and forwards each one over a 4-phase req/ack handshake to a slow receiver.
// Latency: req_out rises one edge after the event is captured; a full FIFO drops new events and sets the sticky overflow flag.
module pulse_hs_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int DW          = 8,
  parameter int DEPTH       = 4
) (
  input  logic                     clk1,
  input  logic                     rstn,
  input  logic                     pulse_in,
  input  logic [DW-1:0]            data_in,
  input  logic                     ack_in,
  input  logic                     ovf_clr,
  output logic                     req_out,
  output logic [DW-1:0]            data_out,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   pend_cnt,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [DW-1:0]          mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   empty;
  logic                   full;
  logic                   pop;
  logic                   push;
  logic                   drop;

  assign ack_s = ack_sync[SYNC_STAGES-1];
  assign empty = (pend_cnt == '0);
  assign full  = (pend_cnt == CNT_FULL);
  assign pop   = (state == IDLE) && !empty;
  // A same-cycle pop frees the slot, so a full FIFO can still accept.
  assign push  = pulse_in && (!full || pop);
  assign drop  = pulse_in && full && !pop;
  assign busy  = (state != IDLE) || !empty;

  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) ack_sync <= '0;
    else       ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
  end

  always_ff @(posedge clk1) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pend_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   pend_cnt <= pend_cnt + 1'b1;
        2'b01:   pend_cnt <= pend_cnt - 1'b1;
        default: pend_cnt <= pend_cnt;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      req_out  <= 1'b0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            data_out <= mem[rd_ptr];
            req_out  <= 1'b1;
            state    <= REQ_HI;
          end
        end
        REQ_HI: begin
          if (ack_s) begin
            req_out <= 1'b0;
            state   <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (!ack_s) state <= IDLE;
        end
        default: begin
          req_out <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_hs_tx.sv
// Bench for pulse_hs_tx: directed handshake scenarios plus a randomized async-ack run
// checked against a queue model of accepted events.
module tb_pulse_hs_tx;

  localparam int SYNC  = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int NXFER = 1000;

  logic                   clk1     = 1'b0;
  logic                   rstn     = 1'b1;
  logic                   pulse_in = 1'b0;
  logic [DW-1:0]          data_in  = '0;
  logic                   ack_in   = 1'b0;
  logic                   ovf_clr  = 1'b0;
  logic                   req_out;
  logic [DW-1:0]          data_out;
  logic                   busy;
  logic [$clog2(DEPTH):0] pend_cnt;
  logic                   overflow;

  int n_chk  = 0;
  int n_pass = 0;

  always #50 clk1 = ~clk1;

  pulse_hs_tx #(.SYNC_STAGES(SYNC), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk1(clk1), .rstn(rstn), .pulse_in(pulse_in), .data_in(data_in),
    .ack_in(ack_in), .ovf_clr(ovf_clr), .req_out(req_out), .data_out(data_out),
    .busy(busy), .pend_cnt(pend_cnt), .overflow(overflow)
  );

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Plays the receiver for one transfer: returns the data seen while req_out was high.
  task automatic recv_one(output logic [DW-1:0] d, output bit ok);
    int t;
    t = 0;
    while (req_out !== 1'b1 && t < 200) begin tick(); t++; end
    ok = (req_out === 1'b1);
    d  = data_out;
    repeat (3) tick();
    ack_in = 1'b1;
    t = 0;
    while (req_out !== 1'b0 && t < 200) begin tick(); t++; end
    ok = ok && (req_out === 1'b0);
    repeat (3) tick();
    ack_in = 1'b0;
    repeat (SYNC + 2) tick();
  endtask

  task automatic test_reset();
    #10 rstn = 1'b0;
    #10;
    n_chk++; if (req_out !== 1'b0) $display("FAIL reset_req got %b want 0", req_out); else n_pass++;
    n_chk++; if (data_out !== '0) $display("FAIL reset_data got %0h want 0", data_out); else n_pass++;
    n_chk++; if (pend_cnt !== '0) $display("FAIL reset_pend got %0d want 0", pend_cnt); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    tick(); tick();
    rstn = 1'b1;
    tick();
    n_chk++; if (busy !== 1'b0 || req_out !== 1'b0) $display("FAIL post_reset_idle got busy=%b req=%b want 0 0", busy, req_out); else n_pass++;
  endtask

  task automatic test_single();
    logic [DW-1:0] r;
    bit ok;
    pulse_in = 1'b1; data_in = 8'hA5;
    tick();
    pulse_in = 1'b0; data_in = '0;
    n_chk++; if (req_out !== 1'b0 || pend_cnt !== 1) $display("FAIL single_capture got req=%b pend=%0d want 0 1", req_out, pend_cnt); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy); else n_pass++;
    tick();
    n_chk++; if (req_out !== 1'b1) $display("FAIL single_req_rise got %b want 1", req_out); else n_pass++;
    n_chk++; if (data_out !== 8'hA5) $display("FAIL single_data got %0h want a5", data_out); else n_pass++;
    n_chk++; if (pend_cnt !== 0) $display("FAIL single_pop got %0d want 0", pend_cnt); else n_pass++;
    recv_one(r, ok);
    n_chk++; if (!ok || r !== 8'hA5) $display("FAIL single_hs got ok=%b d=%0h want 1 a5", ok, r); else n_pass++;
    n_chk++; if (req_out !== 1'b0 || pend_cnt !== 0 || busy !== 1'b0) $display("FAIL single_idle got req=%b pend=%0d busy=%b want 0 0 0", req_out, pend_cnt, busy); else n_pass++;
  endtask

  // With ack held low only the first event is popped; the next DEPTH are stored, later ones dropped.
  task automatic test_fill(input int n, input bit rnd);
    logic [DW-1:0] d[$];
    logic [DW-1:0] r;
    bit ok;
    int stored;
    bit exp_ovf;
    for (int i = 0; i < n; i++) begin
      d.push_back(rnd ? DW'($urandom) : DW'(i + 1));
      pulse_in = 1'b1; data_in = d[i];
      tick();
      pulse_in = 1'b0;
      if (rnd) repeat ($urandom_range(0, 2)) tick();
    end
    tick();
    stored  = (n - 1 > DEPTH) ? DEPTH : n - 1;
    exp_ovf = (n - 1 > DEPTH);
    n_chk++; if (pend_cnt !== stored) $display("FAIL fill_pend n=%0d got %0d want %0d", n, pend_cnt, stored); else n_pass++;
    n_chk++; if (overflow !== exp_ovf) $display("FAIL fill_ovf n=%0d got %b want %b", n, overflow, exp_ovf); else n_pass++;
    n_chk++; if (req_out !== 1'b1 || data_out !== d[0]) $display("FAIL fill_head n=%0d got req=%b d=%0h want 1 %0h", n, req_out, data_out, d[0]); else n_pass++;
    if (exp_ovf) begin
      ovf_clr = 1'b1; pulse_in = 1'b1; data_in = 8'hEE;
      tick();
      pulse_in = 1'b0;
      n_chk++; if (overflow !== 1'b1 || pend_cnt !== DEPTH) $display("FAIL ovf_set_wins got ovf=%b pend=%0d want 1 %0d", overflow, pend_cnt, DEPTH); else n_pass++;
      tick();
      ovf_clr = 1'b0;
      n_chk++; if (overflow !== 1'b0) $display("FAIL ovf_clr got %b want 0", overflow); else n_pass++;
    end
    for (int i = 0; i <= stored; i++) begin
      recv_one(r, ok);
      n_chk++; if (!ok || r !== d[i]) $display("FAIL fill_order n=%0d i=%0d got ok=%b d=%0h want 1 %0h", n, i, ok, r, d[i]); else n_pass++;
    end
    n_chk++; if (pend_cnt !== 0 || busy !== 1'b0 || overflow !== 1'b0) $display("FAIL fill_drain got pend=%0d busy=%b ovf=%b want 0 0 0", pend_cnt, busy, overflow); else n_pass++;
  endtask

  // Full FIFO, then a pulse lands on exactly the edge where IDLE pops the head.
  task automatic test_pop_collision();
    logic [DW-1:0] d[$];
    logic [DW-1:0] r;
    bit ok;
    int t;
    for (int i = 0; i < 6; i++) d.push_back(DW'($urandom));
    for (int i = 0; i < 5; i++) begin
      pulse_in = 1'b1; data_in = d[i];
      tick();
    end
    pulse_in = 1'b0;
    tick();
    n_chk++; if (pend_cnt !== DEPTH || data_out !== d[0]) $display("FAIL coll_full got pend=%0d d=%0h want %0d %0h", pend_cnt, data_out, DEPTH, d[0]); else n_pass++;
    ack_in = 1'b1;
    t = 0;
    while (req_out !== 1'b0 && t < 200) begin tick(); t++; end
    n_chk++; if (req_out !== 1'b0) $display("FAIL coll_req_fall got %b want 0", req_out); else n_pass++;
    ack_in = 1'b0;
    // ack_s falls SYNC edges later, IDLE one edge after that, pop on the next.
    repeat (SYNC + 1) tick();
    pulse_in = 1'b1; data_in = d[5];
    tick();
    pulse_in = 1'b0;
    n_chk++; if (req_out !== 1'b1 || data_out !== d[1]) $display("FAIL coll_pop got req=%b d=%0h want 1 %0h", req_out, data_out, d[1]); else n_pass++;
    n_chk++; if (pend_cnt !== DEPTH) $display("FAIL coll_pend got %0d want %0d", pend_cnt, DEPTH); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL coll_ovf got %b want 0", overflow); else n_pass++;
    for (int i = 1; i < 6; i++) begin
      recv_one(r, ok);
      n_chk++; if (!ok || r !== d[i]) $display("FAIL coll_order i=%0d got ok=%b d=%0h want 1 %0h", i, ok, r, d[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] r;
    logic [DW-1:0] x;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      pulse_in = 1'b1; data_in = DW'($urandom);
      tick();
    end
    pulse_in = 1'b0;
    tick();
    n_chk++; if (req_out !== 1'b1 || pend_cnt !== 2) $display("FAIL rmid_pre got req=%b pend=%0d want 1 2", req_out, pend_cnt); else n_pass++;
    #20 rstn = 1'b0;
    #5;
    n_chk++; if (req_out !== 1'b0) $display("FAIL rmid_req_async got %b want 0", req_out); else n_pass++;
    n_chk++; if (pend_cnt !== 0 || busy !== 1'b0 || data_out !== '0) $display("FAIL rmid_flush got pend=%0d busy=%b d=%0h want 0 0 0", pend_cnt, busy, data_out); else n_pass++;
    @(posedge clk1); #1;
    rstn = 1'b1;
    tick();
    x = DW'($urandom);
    pulse_in = 1'b1; data_in = x;
    tick();
    pulse_in = 1'b0;
    recv_one(r, ok);
    n_chk++; if (!ok || r !== x) $display("FAIL rmid_recover got ok=%b d=%0h want 1 %0h", ok, r, x); else n_pass++;
    n_chk++; if (pend_cnt !== 0 || busy !== 1'b0) $display("FAIL rmid_idle got pend=%0d busy=%b want 0 0", pend_cnt, busy); else n_pass++;
  endtask

  // Random event stream, receiver toggles ack at random phase; every sent event must arrive once, in order.
  task automatic test_async();
    logic [DW-1:0] q[$];
    logic [DW-1:0] expd;
    logic [DW-1:0] pd;
    logic pr;
    int sent, got, changed, cyc, w, dly;
    bit tmo, done;
    sent = 0; got = 0; changed = 0; tmo = 1'b0; done = 1'b0; pr = 1'b0; pd = '0;
    fork
      begin
        cyc = 0;
        while (sent < NXFER && cyc < 40000) begin
          if (pend_cnt < DEPTH - 1 && $urandom_range(0, 2) == 0) begin
            pulse_in = 1'b1; data_in = DW'($urandom);
            q.push_back(data_in);
            sent++;
          end else begin
            pulse_in = 1'b0;
          end
          tick();
          cyc++;
        end
        pulse_in = 1'b0;
      end
      begin
        while (got < NXFER && !tmo) begin
          w = 0;
          do begin @(negedge clk1); w++; end while (req_out !== 1'b1 && w < 2000);
          if (req_out !== 1'b1) begin tmo = 1'b1; break; end
          n_chk++;
          if (q.size() == 0) $display("FAIL async_dup xfer=%0d got %0h want none", got, data_out);
          else begin
            expd = q.pop_front();
            if (data_out !== expd) $display("FAIL async_data xfer=%0d got %0h want %0h", got, data_out, expd);
            else n_pass++;
          end
          dly = $urandom_range(1, 98); if (dly >= 50) dly++;
          #(dly) ack_in = 1'b1;
          w = 0;
          do begin @(negedge clk1); w++; end while (req_out !== 1'b0 && w < 2000);
          if (req_out !== 1'b0) begin tmo = 1'b1; break; end
          dly = $urandom_range(1, 98); if (dly >= 50) dly++;
          #(dly) ack_in = 1'b0;
          got++;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk1);
          if (pr && req_out === 1'b1 && data_out !== pd) changed++;
          pr = req_out;
          pd = data_out;
        end
      end
    join
    repeat (2 * SYNC + 4) tick();
    n_chk++; if (tmo || got != NXFER) $display("FAIL async_count got %0d timeout=%b want %0d 0", got, tmo, NXFER); else n_pass++;
    n_chk++; if (q.size() != 0) $display("FAIL async_lost got %0d pending want 0", q.size()); else n_pass++;
    n_chk++; if (changed != 0) $display("FAIL async_stable got %0d changes want 0", changed); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL async_ovf got %b want 0", overflow); else n_pass++;
    n_chk++; if (busy !== 1'b0 || pend_cnt !== 0) $display("FAIL async_idle got busy=%b pend=%0d want 0 0", busy, pend_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill(4, 1'b0);
    test_fill(6, 1'b0);
    test_fill(1, 1'b0);
    for (int k = 0; k < 4; k++) test_fill($urandom_range(2, 9), 1'b1);
    test_pop_collision();
    test_reset_mid();
    test_async();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
